// File: rtl/eq_pkg.sv
// Shared sizing defaults, sample layout and FSM encoding
// for the stereo sample queue sequencer.
package eq_pkg;

  localparam int DEPTH_DEF    = 1024;
  localparam int NUM_TAPS_DEF = 1021;

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  typedef struct packed {
    logic [15:0] lft;
    logic [15:0] rght;
  } smpl_t;

endpackage

// File: rtl/dp_smpl_ram.sv
// Stereo sample store: one write port, one synchronous
// read port whose output register resets and holds.
module dp_smpl_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/smpl_queue_seq.sv
// Circular stereo sample queue that sequences the newest
// NUM_TAPS samples out to the FIR, oldest first.
module smpl_queue_seq
  import eq_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_TAPS + 1);

  localparam logic [AW-1:0] SPAN = AW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] TAPS = CW'(NUM_TAPS);
  localparam logic [CW-1:0] TM1  = CW'(NUM_TAPS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] new_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] newest;
  logic [AW-1:0] start;
  logic [CW-1:0] fill;
  logic [CW-1:0] k;
  logic          pending;
  logic          full;
  logic          fill_hit;
  logic          last;
  logic          go;
  logic          rd_en;
  smpl_t         wr_smpl;
  smpl_t         rd_smpl;

  assign full     = fill == TAPS;
  assign fill_hit = full || fill == TM1;
  assign last     = k == TAPS;

  // A write in the trigger cycle is itself the window end.
  assign newest = wrt_smpl ? new_ptr
                           : new_ptr - 1'b1;
  assign start  = newest - SPAN;

  assign sequencing = state == READ;
  assign rd_en      = sequencing && !last;

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if ((wrt_smpl && fill_hit) || pending) begin
          go        = 1'b1;
          state_nxt = READ;
        end
      end
      state == READ: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      new_ptr <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      k       <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wrt_smpl) new_ptr <= new_ptr + 1'b1;
      if (wrt_smpl && !full) fill <= fill + 1'b1;
      if (go) begin
        rd_ptr <= start;
        k      <= '0;
      end else if (sequencing) begin
        rd_ptr <= rd_ptr + 1'b1;
        k      <= k + 1'b1;
      end
      if (go)
        pending <= 1'b0;
      else if (sequencing && wrt_smpl)
        pending <= 1'b1;
    end
  end

  assign wr_smpl = '{lft: lft_smpl, rght: rght_smpl};

  dp_smpl_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wrt_smpl),
    .waddr (new_ptr),
    .wdata (wr_smpl),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rd_smpl)
  );

  assign lft_out  = rd_smpl.lft;
  assign rght_out = rd_smpl.rght;

endmodule

// File: tb/tb_smpl_queue_seq.sv
// Scoreboard bench for smpl_queue_seq: a sample-history
// model predicts readout windows and sequencing per cycle.
module tb_smpl_queue_seq;
  import eq_pkg::*;

  localparam int NT = NUM_TAPS_DEF;
  localparam int DP = DEPTH_DEF;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               wrt_smpl = 1'b0;
  logic signed [15:0] lft_smpl = '0;
  logic signed [15:0] rght_smpl = '0;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          sn;
    logic [15:0] l;
    logic [15:0] r;
  } ent_t;

  ent_t hist[$];
  ent_t sb[$];

  bit          m_state;
  int          m_k;
  int          m_fill;
  bit          m_pend;
  int          m_wcnt;
  bit          hold_ok;
  logic [15:0] hold_l;
  logic [15:0] hold_r;

  always #5 clk = ~clk;

  smpl_queue_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic model_reset();
    hist.delete();
    sb.delete();
    m_state = 0;
    m_k     = 0;
    m_fill  = 0;
    m_pend  = 0;
    m_wcnt  = 0;
    hold_ok = 1;
    hold_l  = '0;
    hold_r  = '0;
  endtask

  task automatic model_edge(input bit w,
                            input logic [15:0] l,
                            input logic [15:0] r);
    bit rd;
    rd = m_state;
    if (w) begin
      hist.push_back('{m_wcnt, l, r});
      if (hist.size() > NT) void'(hist.pop_front());
      m_wcnt++;
      if (m_fill < NT) m_fill++;
    end
    if (!rd) begin
      if ((w && m_fill == NT) || m_pend) begin
        m_state = 1;
        m_k     = 0;
        m_pend  = 0;
        foreach (hist[i]) sb.push_back(hist[i]);
      end
    end else begin
      if (w) m_pend = 1;
      if (m_k == NT) m_state = 0;
      else m_k++;
    end
  endtask

  task automatic monitor(input bit w);
    ent_t e;
    int   wb;
    check("seq", 16'(sequencing), 16'(m_state));
    if (m_state && m_k >= 1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 16'(sb.size()), 16'd1);
      end else begin
        e  = sb.pop_front();
        wb = m_wcnt - int'(w);
        if (wb > e.sn + DP) begin
          hold_ok = 0;
        end else begin
          check("lft", lft_out, e.l);
          check("rght", rght_out, e.r);
          hold_l  = e.l;
          hold_r  = e.r;
          hold_ok = 1;
        end
      end
    end else if (!m_state && hold_ok) begin
      check("hold_lft", lft_out, hold_l);
      check("hold_rght", rght_out, hold_r);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit w,
                       input logic [15:0] l,
                       input logic [15:0] r);
    wrt_smpl  = w;
    lft_smpl  = l;
    rght_smpl = r;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(w, l, r);
    #1 monitor(w);
    @(negedge clk);
    wrt_smpl = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    cycle(0, '0, '0);
    while ((m_state || m_pend) && n < 5000) begin
      cycle(0, '0, '0);
      n++;
    end
    if (n >= 5000) check(tag, 16'(m_state), 16'd0);
  endtask

  task automatic wait_k(input int kk, input string tag);
    int n;
    n = 0;
    while (!(m_state && m_k == kk) && n < 5000) begin
      cycle(0, '0, '0);
      n++;
    end
    if (n >= 5000) check(tag, 16'(m_k), 16'(kk));
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_seq", 16'(sequencing), 16'd0);
    check("rst_lft", lft_out, 16'd0);
    check("rst_rght", rght_out, 16'd0);
    @(negedge clk);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Fill: trigger only on the NT-th write.
    for (int i = 0; i < NT; i++)
      cycle(1, 16'(i), 16'(-i));
    check("fill_start", 16'(sequencing), 16'd1);
    wait_done("fill_timeout");
    check("fill_last_l", lft_out, 16'(NT - 1));
    check("fill_last_r", rght_out, 16'(-(NT - 1)));

    // Overlap: write during k=500 queues one readout.
    cycle(1, 16'd4000, 16'd4001);
    wait_k(500, "ovl_timeout");
    cycle(1, 16'd5000, 16'd5001);
    wait_done("ovl_done");
    check("ovl_last_l", lft_out, 16'd5000);
    check("ovl_last_r", rght_out, 16'd5001);

    // Back-to-back: write in the first low cycle.
    cycle(1, 16'd6000, 16'd6001);
    while (m_state) cycle(0, '0, '0);
    check("b2b_low", 16'(sequencing), 16'd0);
    cycle(1, 16'd6002, 16'd6003);
    check("b2b_rise", 16'(sequencing), 16'd1);
    wait_done("b2b_done");
    check("b2b_last", lft_out, 16'd6002);

    // Wrap: 3000 samples across the pointer wrap.
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      cycle(1, 16'(i), 16'(-i));
      idle(7);
    end
    wait_done("wrap_done");
    check("wrap_last_l", lft_out, 16'd2999);
    check("wrap_last_r", rght_out, 16'(-2999));

    // Reset mid-readout at k=300.
    cycle(1, 16'd7000, 16'd7001);
    wait_k(300, "mid_timeout");
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_seq", 16'(sequencing), 16'd0);
    check("mid_rst_lft", lft_out, 16'd0);
    check("mid_rst_rght", rght_out, 16'd0);
    @(negedge clk);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < NT - 1; i++)
      cycle(1, 16'(100 + i), 16'(200 + i));
    idle(3);
    check("refill_quiet", 16'(sequencing), 16'd0);
    cycle(1, 16'd9000, 16'd9001);
    check("refill_start", 16'(sequencing), 16'd1);
    wait_done("refill_done");
    check("refill_last", lft_out, 16'd9000);
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
